// File: rtl/code_ram_loader.sv
// code_ram_loader: writable synchronous instruction memory on the CPU fetch bus.
// After reset the whole array is overwritten with FILL_WORD. A streaming
// loader port then rewrites ranges of words at run time. The CPU is held off
// whenever the contents are being rewritten.
module code_ram_loader #(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 10,
    parameter int                 BUS_AW    = 16,
    parameter logic [DATA_W-1:0]  FILL_WORD = 16'hc800
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BUS_AW-1:0]   code_addr,
    output logic [DATA_W-1:0]   code_content,
    output logic                cpu_hold,
    input  logic                ld_start,
    input  logic [ADDR_W-1:0]   ld_base,
    input  logic [ADDR_W:0]     ld_len,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    output logic                ld_done,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   ptr, ptr_n;
    logic [LEN_W-1:0]    remaining, remaining_n;
    logic                done_n;

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;

    logic [LEN_W-1:0]    len_sat;
    logic                in_range;
    logic [ADDR_W-1:0]   rd_addr;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Word counts beyond the array size are clamped to a full-array load.
    assign len_sat = (ld_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : ld_len;

    // Fetch addresses with any bit set above the array range read as fill.
    if (BUS_AW > ADDR_W) begin : g_wide_bus
        assign in_range = (code_addr[BUS_AW-1:ADDR_W] == '0);
        assign rd_addr  = code_addr[ADDR_W-1:0];
    end else begin : g_narrow_bus
        assign in_range = 1'b1;
        assign rd_addr  = ADDR_W'(code_addr);
    end

    assign cpu_hold = (state != RUN);
    assign busy     = (state != RUN);
    assign ld_ready = (state == LOAD);

    // State register, write pointer, word counter and registered done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            ptr       <= '0;
            remaining <= '0;
            ld_done   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            remaining <= remaining_n;
            ld_done   <= done_n;
        end
    end

    // Next-state logic and memory write-port control.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        remaining_n = remaining;
        done_n      = 1'b0;
        we          = 1'b0;
        waddr       = ptr;
        wdata       = FILL_WORD;

        case (state)
            CLEAR: begin
                we    = 1'b1;
                ptr_n = ptr + 1'b1;
                if (ptr == '1) begin
                    state_n = RUN;
                end
            end

            RUN: begin
                if (ld_start) begin
                    ptr_n       = ld_base;
                    remaining_n = len_sat;
                    if (len_sat == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end

            LOAD: begin
                if (ld_valid) begin
                    we          = 1'b1;
                    wdata       = ld_data;
                    ptr_n       = ptr + 1'b1;
                    remaining_n = remaining - 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state_n = RUN;
                        done_n  = 1'b1;
                    end
                end
            end

            default: begin
                state_n = CLEAR;
            end
        endcase

        // A reset edge aborts any clear or load without touching the array.
        if (reset) begin
            we = 1'b0;
        end
    end

    // Array write port (no reset so it maps onto block RAM).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered fetch port; masked to fill outside RUN or out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            code_content <= FILL_WORD;
        end else if ((state == RUN) && in_range) begin
            code_content <= mem[rd_addr];
        end else begin
            code_content <= FILL_WORD;
        end
    end

endmodule

// File: tb/tb_code_ram_loader.sv
// Directed self-checking bench for code_ram_loader (default parameters).
module tb_code_ram_loader;

    localparam logic [15:0] FILL = 16'hc800;

    logic        clk;
    logic        reset;
    logic [15:0] code_addr;
    logic [15:0] code_content;
    logic        cpu_hold;
    logic        ld_start;
    logic [9:0]  ld_base;
    logic [10:0] ld_len;
    logic [15:0] ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp;
    } fetch_vec_t;

    fetch_vec_t fv[14];

    code_ram_loader #(
        .DATA_W(16),
        .ADDR_W(10),
        .BUS_AW(16),
        .FILL_WORD(16'hc800)
    ) dut (
        .clk(clk),
        .reset(reset),
        .code_addr(code_addr),
        .code_content(code_content),
        .cpu_hold(cpu_hold),
        .ld_start(ld_start),
        .ld_base(ld_base),
        .ld_len(ld_len),
        .ld_data(ld_data),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_done(ld_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] addr, input logic [15:0] exp, input string name);
        code_addr = addr;
        step();
        check(name, {16'h0, code_content}, {16'h0, exp});
    endtask

    // Counts cycles with busy high after reset release, optionally poking
    // ld_start mid-clear, and reports any ld_done seen along the way.
    task automatic count_clear(output int cycles, output int dones);
        cycles = 0;
        dones  = 0;
        while (cycles < 2000) begin
            if (cycles == 100) begin
                ld_start = 1'b1;
                ld_base  = 10'h005;
                ld_len   = 11'd0;
            end else begin
                ld_start = 1'b0;
            end
            step();
            cycles++;
            if (ld_done) dones++;
            if (!busy) break;
        end
        ld_start = 1'b0;
    endtask

    initial begin
        int cyc;
        int dn;
        logic [15:0] words[4];
        logic        vpat[6];
        int          wi;

        reset     = 1'b1;
        code_addr = 16'h0;
        ld_start  = 1'b0;
        ld_base   = '0;
        ld_len    = '0;
        ld_data   = '0;
        ld_valid  = 1'b0;

        step();
        step();
        check("reset_code_content", {16'h0, code_content}, {16'h0, FILL});
        check("reset_cpu_hold", {31'h0, cpu_hold}, 32'd1);
        check("reset_busy", {31'h0, busy}, 32'd1);
        check("reset_ld_ready", {31'h0, ld_ready}, 32'd0);
        check("reset_ld_done", {31'h0, ld_done}, 32'd0);

        // Initial clear: 1024 busy cycles, ld_start ignored, no ld_done.
        reset = 1'b0;
        count_clear(cyc, dn);
        check("clear_cycles", cyc, 32'd1024);
        check("clear_no_done", dn, 32'd0);
        check("run_cpu_hold", {31'h0, cpu_hold}, 32'd0);

        fetch(16'h0000, FILL, "fetch_cleared_000");
        fetch(16'h01ff, FILL, "fetch_cleared_1ff");
        fetch(16'h03ff, FILL, "fetch_cleared_3ff");

        // Contiguous three-word load at 0x10.
        ld_start = 1'b1;
        ld_base  = 10'h010;
        ld_len   = 11'd3;
        step();
        ld_start = 1'b0;
        check("load1_hold", {31'h0, cpu_hold}, 32'd1);
        check("load1_ready", {31'h0, ld_ready}, 32'd1);
        ld_valid = 1'b1;
        ld_data  = 16'h2601; step();
        check("load1_no_early_done", {31'h0, ld_done}, 32'd0);
        ld_data  = 16'h0a00; step();
        ld_data  = 16'h0210; step();
        ld_valid = 1'b0;
        check("load1_done", {31'h0, ld_done}, 32'd1);
        check("load1_ready_drop", {31'h0, ld_ready}, 32'd0);
        check("load1_hold_drop", {31'h0, cpu_hold}, 32'd0);
        fetch(16'h0010, 16'h2601, "load1_first_fetch");
        check("load1_done_single", {31'h0, ld_done}, 32'd0);

        // Wrapping load with gapped valid; a stray ld_start mid-load must be ignored.
        words = '{16'ha0a1, 16'hb0b1, 16'hc0c1, 16'hd0d1};
        vpat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ld_start = 1'b1;
        ld_base  = 10'h3fe;
        ld_len   = 11'd4;
        step();
        ld_start = 1'b0;
        wi = 0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            ld_valid = vpat[i];
            ld_data  = vpat[i] ? words[wi] : 16'hdead;
            if (i == 1) begin
                ld_start = 1'b1;
                ld_base  = 10'h100;
                ld_len   = 11'd1;
            end else begin
                ld_start = 1'b0;
            end
            step();
            if (vpat[i]) wi++;
            if (ld_done) dn++;
            if (i == 4) check("wrap_no_early_done", {31'h0, ld_done}, 32'd0);
        end
        check("wrap_done_last", {31'h0, ld_done}, 32'd1);
        ld_valid = 1'b0;
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ld_done) dn++;
        end
        check("wrap_done_once", dn, 32'd1);

        // Zero-length load: done next cycle, no hold, nothing written.
        ld_start = 1'b1;
        ld_base  = 10'h010;
        ld_len   = 11'd0;
        step();
        ld_start = 1'b0;
        check("len0_done", {31'h0, ld_done}, 32'd1);
        check("len0_hold", {31'h0, cpu_hold}, 32'd0);
        step();
        check("len0_done_clear", {31'h0, ld_done}, 32'd0);
        check("len0_hold_after", {31'h0, cpu_hold}, 32'd0);

        fv[0]  = '{16'h0010, 16'h2601};
        fv[1]  = '{16'h0011, 16'h0a00};
        fv[2]  = '{16'h0012, 16'h0210};
        fv[3]  = '{16'h0013, FILL};
        fv[4]  = '{16'h03fe, 16'ha0a1};
        fv[5]  = '{16'h03ff, 16'hb0b1};
        fv[6]  = '{16'h0000, 16'hc0c1};
        fv[7]  = '{16'h0001, 16'hd0d1};
        fv[8]  = '{16'h0002, FILL};
        fv[9]  = '{16'h03fd, FILL};
        fv[10] = '{16'h0100, FILL};
        fv[11] = '{16'h0400, FILL};
        fv[12] = '{16'hffff, FILL};
        fv[13] = '{16'h0411, FILL};
        for (int i = 0; i < 14; i++) begin
            fetch(fv[i].addr, fv[i].exp, $sformatf("table_fetch_%0d_addr_%h", i, fv[i].addr));
        end

        // Reset after the 2nd of 5 words aborts the load and refills the array.
        ld_start = 1'b1;
        ld_base  = 10'h020;
        ld_len   = 11'd5;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 16'h1234; step();
        ld_data  = 16'h5678; step();
        ld_data  = 16'h9abc;
        reset    = 1'b1;
        step();
        check("abort_done_low", {31'h0, ld_done}, 32'd0);
        check("abort_busy", {31'h0, busy}, 32'd1);
        check("abort_ready_low", {31'h0, ld_ready}, 32'd0);
        reset    = 1'b0;
        ld_valid = 1'b0;
        count_clear(cyc, dn);
        check("abort_clear_cycles", cyc, 32'd1024);
        check("abort_no_done", dn, 32'd0);
        fetch(16'h0020, FILL, "abort_fetch_020");
        fetch(16'h0021, FILL, "abort_fetch_021");
        fetch(16'h0022, FILL, "abort_fetch_022");
        fetch(16'h0010, FILL, "abort_fetch_010");
        fetch(16'h03fe, FILL, "abort_fetch_3fe");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
